// File: rtl/if_id_hazard_ctrl.sv
// PC / IF-ID pipeline sequencer: load-use stall, branch/jump flush, imem wait handling.
// Control outputs are combinational from current state and inputs; state and counters are registered.
module if_id_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned WAIT_TIMEOUT      = 255,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [5:0]       Op_code_in,
  input  logic [4:0]       IF_ID_Rs_in,
  input  logic [4:0]       IF_ID_Rt_in,
  input  logic             ID_EX_MemRead_in,
  input  logic [4:0]       ID_EX_Rt_in,
  input  logic             Branch_taken_in,
  input  logic             imem_ready_in,
  output logic             PC_write_out,
  output logic             IF_ID_enable_out,
  output logic             IF_ID_flush_out,
  output logic             ID_EX_bubble_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] flush_cnt_out,
  output logic             timeout_err_out
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_IMEM_WAIT  = 2'd2,
    ST_UNUSED     = 2'd3
  } state_e;

  localparam logic [3:0]       HOLD_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0]       WAIT_MAX  = 8'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic uses_rt, is_jump, hazard;

  // Decode of the instruction sitting in IF/ID
  assign uses_rt = (Op_code_in == 6'h00) || (Op_code_in == 6'h04) ||
                   (Op_code_in == 6'h05) || (Op_code_in == 6'h2B);
  assign is_jump = (Op_code_in == 6'h02) || (Op_code_in == 6'h03);
  assign hazard  = ID_EX_MemRead_in && (ID_EX_Rt_in != 5'd0) &&
                   ((ID_EX_Rt_in == IF_ID_Rs_in) || (uses_rt && (ID_EX_Rt_in == IF_ID_Rt_in)));

  always_comb begin
    state_d          = state_q;
    hold_d           = hold_q;
    wait_d           = wait_q;
    err_d            = err_q;
    PC_write_out     = 1'b0;
    IF_ID_enable_out = 1'b0;
    IF_ID_flush_out  = 1'b0;
    ID_EX_bubble_out = 1'b0;

    if (reset_in) begin
      IF_ID_flush_out  = 1'b1;
      ID_EX_bubble_out = 1'b1;
      state_d          = ST_RUN;
      hold_d           = 4'd0;
      wait_d           = 8'd0;
      err_d            = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Branch_taken_in) begin
            {PC_write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out} = 4'b1111;
          end else if (is_jump) begin
            {PC_write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out} = 4'b1110;
          end else if (hazard) begin
            ID_EX_bubble_out = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_LOAD_STALL;
              hold_d  = HOLD_INIT;
            end
          end else if (!imem_ready_in) begin
            ID_EX_bubble_out = 1'b1;
            state_d          = ST_IMEM_WAIT;
            wait_d           = 8'd1;
          end else begin
            {PC_write_out, IF_ID_enable_out} = 2'b11;
          end
        end
        ST_LOAD_STALL: begin
          if (Branch_taken_in) begin
            {PC_write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out} = 4'b1111;
            state_d = ST_RUN;
            hold_d  = 4'd0;
          end else begin
            ID_EX_bubble_out = 1'b1;
            hold_d           = hold_q - 4'd1;
            if (hold_q <= 4'd1) begin
              state_d = ST_RUN;
              hold_d  = 4'd0;
            end
          end
        end
        ST_IMEM_WAIT: begin
          if (Branch_taken_in) begin
            {PC_write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out} = 4'b1111;
            state_d = ST_RUN;
            wait_d  = 8'd0;
          end else if (imem_ready_in) begin
            {PC_write_out, IF_ID_enable_out} = 2'b11;
            state_d = ST_RUN;
            wait_d  = 8'd0;
          end else begin
            ID_EX_bubble_out = 1'b1;
            if (wait_q < WAIT_MAX) wait_d = wait_q + 8'd1;
          end
        end
        default: begin
          IF_ID_flush_out  = 1'b1;
          ID_EX_bubble_out = 1'b1;
          state_d          = ST_RUN;
          hold_d           = 4'd0;
          wait_d           = 8'd0;
        end
      endcase
      // Error latches on the edge where the wait count reaches the limit
      if ((state_d == ST_IMEM_WAIT) && (wait_d == WAIT_MAX)) err_d = 1'b1;
    end
  end

  // Saturating performance counters, cleared by reset
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset_in) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!PC_write_out && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (IF_ID_flush_out && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    hold_q      <= hold_d;
    wait_q      <= wait_d;
    err_q       <= err_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign state_out       = state_q;
  assign stall_cnt_out   = stall_cnt_q;
  assign flush_cnt_out   = flush_cnt_q;
  assign timeout_err_out = err_q;

endmodule
